// File: rtl/inst_fetch_queue.sv
// Instruction-fetch stage: issues sequential reads to a synchronous I-mem and buffers
// the returned {pc, instruction} pairs in a DEPTH-entry queue for decode.
module inst_fetch_queue #(
    parameter int               ADDR_W   = 16,
    parameter int               INST_W   = 16,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     branch_to_new,
    input  logic [ADDR_W-1:0]        branch_pc,
    output logic [ADDR_W-1:0]        imem_addr,
    output logic                     imem_rd,
    input  logic [INST_W-1:0]        imem_q,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [INST_W-1:0]        inst,
    output logic [ADDR_W-1:0]        pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {BOOT, RUN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  tag_q, tag_d;
    logic               inflight_q, inflight_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INST_W-1:0]  hold_inst_q, hold_inst_d;
    logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;

    logic [INST_W-1:0]  slot_inst [DEPTH];
    logic [ADDR_W-1:0]  slot_pc   [DEPTH];

    logic               run;
    logic               redirect;
    logic               has_head;
    logic               pop;
    logic               push;
    logic [CNT_W:0]     occupancy;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        tag_d       = tag_q;
        inflight_d  = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase

        run      = (state_q == RUN);
        redirect = run & branch_to_new;
        has_head = (count_q != '0);

        inst_valid = has_head & ~branch_to_new;
        pop        = inst_valid & inst_ready;
        // A response landing in a redirect cycle belongs to the old stream
        push       = inflight_q & ~branch_to_new;

        // Entries already held or still on their way, minus the one leaving now
        occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        imem_rd   = run & (branch_to_new | (occupancy < (CNT_W+1)'(DEPTH)));
        imem_addr = redirect ? branch_pc : fetch_pc_q;

        inst = has_head ? slot_inst[rd_ptr_q] : hold_inst_q;
        pc   = has_head ? slot_pc[rd_ptr_q]   : hold_pc_q;
        q_count = count_q;

        if (has_head) begin
            hold_inst_d = slot_inst[rd_ptr_q];
            hold_pc_d   = slot_pc[rd_ptr_q];
        end

        if (imem_rd) begin
            fetch_pc_d = imem_addr + ADDR_W'(1);
            tag_d      = imem_addr;
            inflight_d = 1'b1;
        end

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            tag_q       <= RESET_PC;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            tag_q       <= tag_d;
            inflight_q  <= inflight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    // Queue storage needs no reset: it is only read while count_q is non-zero
    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            slot_inst[wr_ptr_q] <= imem_q;
            slot_pc[wr_ptr_q]   <= tag_q;
        end
    end

endmodule
